// File: rtl/fp_issue_pkg.sv
// Shared types for the fp_add_sub issuer front end.
// The result tag field exists only when FP_ISSUE_TAG_EN is defined.
package fp_issue_pkg;

    localparam int FP_W = 32;
`ifdef FP_ISSUE_TAG_EN
    localparam int TAG_W = 4;
`endif

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_DRAIN
    } state_e;

    typedef struct packed {
`ifdef FP_ISSUE_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
        logic [FP_W-1:0]  data;
    } result_t;

endpackage

// File: rtl/fp_res_fifo.sv
// Synchronous first-word-fall-through FIFO for captured core results.
// Reads while empty return zero, so downstream data is clean whenever nothing is buffered.
module fp_res_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      count_q;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign doPop   = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            case ({push_i, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; the empty-gated read hides stale words.
    always_ff @(posedge clk) begin
        if (push_i && !rst && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

    assert property (@(posedge clk) disable iff (rst || flush_i)
                     !(push_i && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/fp_add_sub_issuer.sv
// Ready/valid front end for the pipelined fp_add_sub core: issues operands, tracks them through
// the fixed core latency and buffers results with credit backpressure. FP_ISSUE_TAG_EN adds tags.
module fp_add_sub_issuer
    import fp_issue_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [FP_W-1:0]  cmd_num1,
    input  logic [FP_W-1:0]  cmd_num2,
    input  logic             cmd_op,
`ifdef FP_ISSUE_TAG_EN
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [TAG_W-1:0] res_tag,
`endif
    output logic [FP_W-1:0]  num1,
    output logic [FP_W-1:0]  num2,
    output logic             op,
    input  logic [FP_W-1:0]  S,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [FP_W-1:0]  res_data,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e          state_q, state_d;
    logic [FP_W-1:0] num1_q, num2_q;
    op_e             op_q;
    logic [LAT-1:0]  validSr_q, validSr_d;
    logic [CW-1:0]   inflightCnt_q, inflightCnt_d;
    logic [CW-1:0]   fifoCnt, fifoCnt_d, outstanding;
    logic            busy_q;
    logic            clear, accept, capture, pop, fifoEmpty;
    result_t         pushEntry, headEntry;

    assign clear = rst || flush;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_DRAIN;
            S_DRAIN: state_d = S_RUN;
            default: state_d = S_RESET;
        endcase
    end

    // Credit uses registered counters only, so res_ready never reaches cmd_ready combinationally.
    always_comb begin
        outstanding = inflightCnt_q + fifoCnt;
        cmd_ready   = (state_q == S_RUN) && !rst && !flush && (outstanding < CW'(DEPTH));
    end

    assign accept  = cmd_valid && cmd_ready;
    assign capture = validSr_q[LAT-1] && !clear;
    assign pop     = res_ready && !fifoEmpty;

    always_comb begin
        validSr_d    = validSr_q << 1;
        validSr_d[0] = accept;
        if (clear) validSr_d = '0;

        inflightCnt_d = inflightCnt_q;
        if (clear)                 inflightCnt_d = '0;
        else if (accept && !capture) inflightCnt_d = inflightCnt_q + CW'(1);
        else if (!accept && capture) inflightCnt_d = inflightCnt_q - CW'(1);

        fifoCnt_d = fifoCnt;
        if (clear)                 fifoCnt_d = '0;
        else if (capture && !pop)  fifoCnt_d = fifoCnt + CW'(1);
        else if (!capture && pop)  fifoCnt_d = fifoCnt - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num1_q <= '0;
            num2_q <= '0;
            op_q   <= OP_ADD;
        end else begin
            num1_q <= accept ? cmd_num1 : '0;
            num2_q <= accept ? cmd_num2 : '0;
            op_q   <= accept ? op_e'(cmd_op) : OP_ADD;
        end
        validSr_q     <= validSr_d;
        inflightCnt_q <= inflightCnt_d;
        busy_q        <= (inflightCnt_d + fifoCnt_d) != '0;
    end

`ifdef FP_ISSUE_TAG_EN
    logic [TAG_W-1:0] tagSr_q [LAT];

    always_ff @(posedge clk) begin
        tagSr_q[0] <= accept ? cmd_tag : '0;
        for (int i = 1; i < LAT; i++) tagSr_q[i] <= tagSr_q[i-1];
    end

    assign res_tag = headEntry.tag;
`endif

    always_comb begin
        pushEntry      = '0;
        pushEntry.data = S;
`ifdef FP_ISSUE_TAG_EN
        pushEntry.tag  = tagSr_q[LAT-1];
`endif
    end

    fp_res_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (DEPTH)
    ) uResFifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (capture),
        .data_i  (pushEntry),
        .pop_i   (pop),
        .data_o  (headEntry),
        .empty_o (fifoEmpty),
        .count_o (fifoCnt)
    );

    assign num1      = num1_q;
    assign num2      = num2_q;
    assign op        = op_q;
    assign res_valid = !fifoEmpty;
    assign res_data  = headEntry.data;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_add_sub_issuer.sv
// Bench for fp_add_sub_issuer: directed scenarios plus randomized traffic checked against
// a queue-based model of issue, latency, credit, flush and in-order result delivery.
`timescale 1ns/1ps
module tb_fp_add_sub_issuer;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, flush, cmd_valid, cmd_ready, cmd_op;
    logic [31:0] cmd_num1, cmd_num2, num1, num2, S, res_data;
    logic        op, res_valid, res_ready, busy;
    logic [3:0]  cmdTag;
`ifdef FP_ISSUE_TAG_EN
    logic [3:0]  res_tag;
`endif

    fp_add_sub_issuer #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_num1  (cmd_num1),
        .cmd_num2  (cmd_num2),
        .cmd_op    (cmd_op),
`ifdef FP_ISSUE_TAG_EN
        .cmd_tag   (cmdTag),
        .res_tag   (res_tag),
`endif
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .S         (S),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic real toReal(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'h0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] toSingle(input real r);
        logic [63:0] d;
        logic [30:0] mag;
        logic        guard, sticky;
        if (r == 0.0) return 32'h0;
        d      = $realtobits(r);
        mag    = {8'(int'(d[62:52]) - 896), d[51:29]};
        guard  = d[28];
        sticky = |d[27:0];
        if (guard && (sticky || mag[0])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] fpAddSub(input logic [31:0] a, input logic [31:0] b, input logic o);
        return toSingle(o ? toReal(a) - toReal(b) : toReal(a) + toReal(b));
    endfunction

    function automatic logic [31:0] randFloat();
        logic [31:0] f;
        f[31]    = 1'($urandom_range(0, 1));
        f[30:23] = 8'($urandom_range(120, 134));
        f[22:0]  = 23'($urandom);
        return f;
    endfunction

    // Behavioural core: LAT-1 register stages after the issuer's operand registers.
    logic [31:0] corePipe [LAT-1];
    always @(posedge clk) begin
        corePipe[0] <= fpAddSub(num1, num2, op);
        for (int i = 1; i < LAT-1; i++) corePipe[i] <= corePipe[i-1];
    end
    assign S = corePipe[LAT-2];

    typedef struct { logic [31:0] data; logic [3:0] tag; int due; } flight_t;
    typedef struct { logic [31:0] data; logic [3:0] tag; } entry_t;

    flight_t     mInflight[$];
    entry_t      mFifo[$];
    logic [31:0] mNum1 = 32'h0, mNum2 = 32'h0;
    logic        mOp = 1'b0, mBlocked = 1'b1, modelValid = 1'b0, lastAccepted = 1'b0;
    int          checkCount = 0, passCount = 0, acceptCount = 0;
    logic [31:0] popLog[$];
    logic [3:0]  tagLog[$];
    logic [31:0] bpA[12], bpB[12];
    logic        bpOp[12];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b, input logic o,
                                 input logic [3:0] t, input logic rr, input logic fl, input logic rs);
        logic    expReady;
        entry_t  head;
        flight_t nf;
        entry_t  ne;
        cmd_valid = v; cmd_num1 = a; cmd_num2 = b; cmd_op = o; cmdTag = t;
        res_ready = rr; flush = fl; rst = rs;
        @(negedge clk);
        expReady = !rs && !fl && !mBlocked && ((mInflight.size() + mFifo.size()) < DEPTH);
        head.data = 32'h0;
        head.tag  = 4'h0;
        if (mFifo.size() != 0) head = mFifo[0];
        if (modelValid) begin
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(expReady));
            checkOutput("res_valid", 32'(res_valid), 32'(mFifo.size() != 0));
            checkOutput("res_data", res_data, head.data);
`ifdef FP_ISSUE_TAG_EN
            checkOutput("res_tag", 32'(res_tag), 32'(head.tag));
`endif
            checkOutput("num1", num1, mNum1);
            checkOutput("num2", num2, mNum2);
            checkOutput("op", 32'(op), 32'(mOp));
            checkOutput("busy", 32'(busy), 32'((mInflight.size() + mFifo.size()) != 0));
            checkOutput("fifo_cnt", 32'(dut.uResFifo.count_q), 32'(mFifo.size()));
        end
        if (cmd_valid && cmd_ready) acceptCount++;
        if (res_valid && res_ready) begin
            popLog.push_back(res_data);
`ifdef FP_ISSUE_TAG_EN
            tagLog.push_back(res_tag);
`endif
        end
        @(posedge clk);
        lastAccepted = 1'b0;
        if (rs || fl) begin
            mInflight.delete();
            mFifo.delete();
            mNum1 = 32'h0; mNum2 = 32'h0; mOp = 1'b0;
            mBlocked = 1'b1;
            if (rs) modelValid = 1'b1;
        end else begin
            if (rr && mFifo.size() != 0) void'(mFifo.pop_front());
            foreach (mInflight[i]) mInflight[i].due--;
            while (mInflight.size() != 0 && mInflight[0].due == 0) begin
                nf = mInflight.pop_front();
                ne.data = nf.data;
                ne.tag  = nf.tag;
                mFifo.push_back(ne);
            end
            lastAccepted = v && expReady;
            if (lastAccepted) begin
                nf.data = fpAddSub(a, b, o);
                nf.tag  = t;
                nf.due  = LAT;
                mInflight.push_back(nf);
                mNum1 = a; mNum2 = b; mOp = o;
            end else begin
                mNum1 = 32'h0; mNum2 = 32'h0; mOp = 1'b0;
            end
            mBlocked = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, rr, 1'b0, 1'b0);
    endtask

    task automatic offerCmd(input logic [31:0] a, input logic [31:0] b, input logic o,
                            input logic [3:0] t, input logic rr);
        int tries = 0;
        do begin
            applyStimulus(1'b1, a, b, o, t, rr, 1'b0, 1'b0);
            tries++;
        end while (!lastAccepted && tries < 40);
        if (!lastAccepted) checkOutput("acceptTimeout", 32'(lastAccepted), 32'h1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic prevFl;
        logic v, rr, fl;
        cmd_valid = 0; cmd_num1 = 0; cmd_num2 = 0; cmd_op = 0; cmdTag = 0;
        res_ready = 0; flush = 0; rst = 1;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1, 1'b1);

        // Single subtract with visible core inputs and a known result.
        popLog.delete();
        offerCmd(32'h4121C28F, 32'h3F8E147B, 1'b1, 4'h3, 1'b1);
        checkOutput("singleNum1", num1, 32'h4121C28F);
        checkOutput("singleNum2", num2, 32'h3F8E147B);
        checkOutput("singleOp", 32'(op), 32'h1);
        idle(LAT + 2, 1'b1);
        checkOutput("singleCount", 32'(popLog.size()), 32'd1);
        if (popLog.size() > 0) checkOutput("singleRes", popLog[0], 32'h41100000);

        // Back-to-back issue with tags.
        popLog.delete();
        tagLog.delete();
        offerCmd(32'h4121C28F, 32'h3F8E147B, 1'b1, 4'h3, 1'b1);
        offerCmd(32'hC121C28F, 32'h3F8E147B, 1'b1, 4'h7, 1'b1);
        idle(LAT + 2, 1'b1);
        checkOutput("b2bCount", 32'(popLog.size()), 32'd2);
        if (popLog.size() > 1) begin
            checkOutput("b2bRes0", popLog[0], 32'h41100000);
            checkOutput("b2bRes1", popLog[1], 32'hC133851E);
        end
`ifdef FP_ISSUE_TAG_EN
        if (tagLog.size() > 1) begin
            checkOutput("b2bTag0", 32'(tagLog[0]), 32'h3);
            checkOutput("b2bTag1", 32'(tagLog[1]), 32'h7);
        end
`endif

        // Backpressure: twelve commands offered, credit admits DEPTH.
        popLog.delete();
        acceptCount = 0;
        for (int i = 0; i < 12; i++) begin
            bpA[i] = randFloat(); bpB[i] = randFloat(); bpOp[i] = 1'($urandom_range(0, 1));
        end
        begin
            int idx = 0;
            for (int c = 0; c < 20; c++) begin
                applyStimulus(1'b1, bpA[idx], bpB[idx], bpOp[idx], 4'(idx), 1'b0, 1'b0, 1'b0);
                if (lastAccepted && idx < 11) idx++;
            end
        end
        checkOutput("bpAccepted", 32'(acceptCount), 32'(DEPTH));
        checkOutput("bpReadyLow", 32'(cmd_ready), 32'h0);
        idle(12, 1'b1);
        checkOutput("bpDrained", 32'(popLog.size()), 32'(DEPTH));
        if (popLog.size() == DEPTH) begin
            checkOutput("bpFirst", popLog[0], fpAddSub(bpA[0], bpB[0], bpOp[0]));
            checkOutput("bpLast", popLog[7], fpAddSub(bpA[7], bpB[7], bpOp[7]));
        end
        checkOutput("bpReadyBack", 32'(cmd_ready), 32'h1);

        // Capture and pop on the same edge with four entries buffered.
        popLog.delete();
        for (int i = 0; i < DEPTH; i++) offerCmd(randFloat(), randFloat(), 1'($urandom_range(0, 1)), 4'(i), 1'b0);
        checkOutput("ppCntBefore", 32'(dut.uResFifo.count_q), 32'd4);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        checkOutput("ppCntAfter", 32'(dut.uResFifo.count_q), 32'd4);
        idle(LAT + DEPTH, 1'b1);
        checkOutput("ppDrained", 32'(popLog.size()), 32'(DEPTH));

        // Flush with two buffered and three in flight.
        popLog.delete();
        offerCmd(randFloat(), randFloat(), 1'b0, 4'h1, 1'b0);
        offerCmd(randFloat(), randFloat(), 1'b1, 4'h2, 1'b0);
        idle(LAT, 1'b0);
        for (int i = 0; i < 3; i++) offerCmd(randFloat(), randFloat(), 1'b0, 4'(i), 1'b0);
        applyStimulus(1'b1, randFloat(), randFloat(), 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("flushValid", 32'(res_valid), 32'h0);
        checkOutput("flushBusy", 32'(busy), 32'h0);
        idle(LAT + 2, 1'b1);
        checkOutput("flushNoStale", 32'(popLog.size()), 32'd0);

        // Randomized traffic with occasional flushes.
        prevFl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            fl = !prevFl && ($urandom_range(0, 49) == 0);
            rr = !fl && ($urandom_range(0, 2) != 0);
            applyStimulus(v, randFloat(), randFloat(), 1'($urandom_range(0, 1)), 4'($urandom), rr, fl, 1'b0);
            prevFl = fl;
        end
        idle(LAT + DEPTH + 2, 1'b1);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) offerCmd(randFloat(), randFloat(), 1'b1, 4'(i), 1'b0);
        idle(LAT, 1'b0);
        applyStimulus(1'b1, randFloat(), randFloat(), 1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
        checkOutput("rstNum1", num1, 32'h0);
        checkOutput("rstNum2", num2, 32'h0);
        checkOutput("rstOp", 32'(op), 32'h0);
        checkOutput("rstResValid", 32'(res_valid), 32'h0);
        checkOutput("rstResData", res_data, 32'h0);
        checkOutput("rstBusy", 32'(busy), 32'h0);
        checkOutput("rstReady", 32'(cmd_ready), 32'h0);
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
